if_stage: RTL
=============

# if_stage

Instruction-fetch stage of the multi-cycle/pipelined LoongArch core. It owns the PC, issues fetches to the synchronous instruction SRAM, and hands `{pc, inst}` to the decode stage with a valid/allowin handshake. It accepts branch redirects from decode, cancels the wrong-path instruction, and buffers both a stalled instruction and a deferred redirect target. It sits directly upstream of the decode/execute logic and replaces the free-running `pc` register of the single-cycle top.

## Interface
- `RESET_PC`, default 32'h1c000000: address of the first fetch after reset.
- `clk`  in  1: core clock; all state is on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `inst_sram_en`  out  1: fetch request this cycle.
- `inst_sram_we`  out  1: tied 0.
- `inst_sram_addr`  out  32: fetch address (`nextpc`).
- `inst_sram_wdata`  out  32: tied 0.
- `inst_sram_rdata`  in  32: read data, valid the cycle after `en`.
- `ds_allowin`  in  1: decode can accept an instruction this cycle.
- `br_taken`  in  1: one-cycle redirect pulse from decode.
- `br_target`  in  32: redirect address, qualified by `br_taken`.
- `fs_to_ds_valid`  out  1: `fs_pc` and `fs_inst` are a valid, non-cancelled instruction.
- `fs_pc`  out  32: PC of the IF-stage instruction.
- `fs_inst`  out  32: instruction word.

## Operation
- State:
  - `fs_valid`
  - `fs_pc`, reset to `RESET_PC-4`, the same trick used in the single-cycle top
  - `inst_buf[31:0]`, `inst_buf_valid`
  - `br_buf[31:0]`, `br_buf_valid`
- Handshake:
  - `fs_ready_go` = 1.
  - `fs_allowin` = ~`fs_valid` | `ds_allowin`.
  - `fs_to_ds_valid` = `fs_valid` & ~`br_taken`.
  - A transfer occurs when `fs_to_ds_valid` & `ds_allowin`.
- Next PC, in priority order:
  1. `br_taken` → `br_target`
  2. `br_buf_valid` → `br_buf`
  3. otherwise `fs_pc`+4 (mod 2^32, wraps silently)
- Fetch:
  - `inst_sram_en` = `fs_allowin` & ~`reset`.
  - `inst_sram_addr` = `nextpc` whether or not `en` is asserted.
  - On an edge with `fs_allowin`: `fs_valid`←1, `fs_pc`←`nextpc`, `br_buf_valid`←0, `inst_buf_valid`←0.
- Redirect while stalled (`br_taken` & ~`fs_allowin`):
  - `fs_valid`←0, which cancels the wrong-path instruction.
  - `br_buf`←`br_target`, `br_buf_valid`←1, `inst_buf_valid`←0.
  - The next cycle `fs_allowin`=1, so `br_buf` is fetched.
- Instruction hold:
  - The SRAM is not required to hold `rdata` while `en`=0.
  - On an edge with `fs_valid` & ~`ds_allowin` & ~`inst_buf_valid` & ~`br_taken`: `inst_buf`←`inst_sram_rdata`, `inst_buf_valid`←1.
  - `fs_inst` = `inst_buf_valid` ? `inst_buf` : `inst_sram_rdata`.
- Simultaneous `br_taken` and `ds_allowin`: the branch target is fetched immediately and the current IF instruction is dropped, never transferred.
- `br_taken` while `br_buf_valid`: the newer target overwrites `br_buf`.

## Timing
- While `reset`=1:
  - `inst_sram_en`=0, `fs_to_ds_valid`=0.
  - `fs_pc`=`RESET_PC-4`, `fs_inst`=`inst_sram_rdata`.
  - All buffers invalid, `inst_sram_addr`=`RESET_PC`.
- Cycle 0 after deassertion: `en`=1, `addr`=`RESET_PC`.
- Cycle 1: `fs_valid`=1, `fs_pc`=`RESET_PC`, `fs_inst`=the SRAM word.
- Fetch-to-valid latency is 1 cycle. With decode never stalling, throughput is 1 instruction per cycle.
- Redirect penalty:
  - 1 bubble when `fs_allowin`.
  - 2+ cycles when deferred: the target is fetched on the first cycle after the stall edge and is valid the cycle after that.
- Asserting `reset` mid-operation clears state immediately, asynchronously. Any SRAM data in flight is ignored.

## Structure
- Shared package holds:
  - `RESET_PC`
  - `FS_TO_DS_BUS_WD`=64, packing `{fs_inst, fs_pc}`
  - `BR_BUS_WD`=33, packing `{br_taken, br_target}`
- Optional bus-packed port variants use these widths.
- No sub-module is needed. The inst/branch buffers stay inline, about 150 lines.

## Test plan
- Reset release with `ds_allowin`=1 → `addr` sequence 0x1c000000, 0x1c000004, 0x1c000008. `fs_to_ds_valid` rises one cycle after `en` and `fs_pc` tracks each address.
- Stall: `fs_pc`=0x1c000008 with `ds_allowin`=0 for 3 cycles while `rdata` is driven 0xdeadbeef after the first stall cycle → `en`=0, and `fs_inst` holds the original word throughout. On release the same `pc`/`inst` transfer once, then 0x1c00000c is fetched.
- Redirect unstalled: `br_taken`=1, `target`=0x1c000100 → same cycle `addr`=0x1c000100 and `fs_to_ds_valid`=0. Next cycle `fs_pc`=0x1c000100.
- Redirect stalled: `ds_allowin`=0 with `br_taken` pulse, `target`=0x1c000200 → next cycle `fs_valid`=0, `en`=1, `addr`=0x1c000200. One cycle later `fs_pc`=0x1c000200.
- Wrap-around: `RESET_PC`=32'hfffffffc → second fetch address is 0x00000000.
- Asynchronous reset mid-stream with `fs_valid`=1 and `br_buf_valid`=1 → `fs_to_ds_valid` drops with no clock edge, and after release fetching restarts at `RESET_PC`.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared fetch-stage types and constants.
// Bus widths match the packed decode/branch bundles.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC = 32'h1c00_0000;
    localparam int FS_TO_DS_BUS_WD = 64;
    localparam int BR_BUS_WD = 33;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fs_to_ds_t;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } br_bus_t;

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, drives the inst SRAM and
// hands {pc, inst} to decode with stall and redirect buffering.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = if_stage_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_sram_en,
    output logic        inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata,
    input  logic        ds_allowin,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst
);

    br_bus_t     br;
    fs_to_ds_t   ds_bus;
    logic        fs_valid;
    logic [31:0] pc_q;
    logic [31:0] inst_buf;
    logic        inst_buf_valid;
    logic [31:0] br_buf;
    logic        br_buf_valid;
    logic        fs_ready_go;
    logic        fs_allowin;
    logic [31:0] nextpc;

    assign br = '{taken: br_taken, target: br_target};

    assign fs_ready_go    = 1'b1;
    assign fs_allowin     = ~fs_valid | (fs_ready_go & ds_allowin);
    assign fs_to_ds_valid = fs_valid & fs_ready_go & ~br.taken;

    always_comb begin
        nextpc = seq_pc(pc_q);
        if (br.taken) begin
            nextpc = br.target;
        end else if (br_buf_valid) begin
            nextpc = br_buf;
        end
    end

    assign inst_sram_en    = fs_allowin & ~reset;
    assign inst_sram_we    = 1'b0;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_wdata = 32'd0;

    // A stall redirect drops the wrong-path word and parks the target.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fs_valid       <= 1'b0;
            pc_q           <= RESET_PC - 32'd4;
            inst_buf       <= 32'd0;
            inst_buf_valid <= 1'b0;
            br_buf         <= 32'd0;
            br_buf_valid   <= 1'b0;
        end else if (fs_allowin) begin
            fs_valid       <= 1'b1;
            pc_q           <= nextpc;
            inst_buf_valid <= 1'b0;
            br_buf_valid   <= 1'b0;
        end else if (br.taken) begin
            fs_valid       <= 1'b0;
            br_buf         <= br.target;
            br_buf_valid   <= 1'b1;
            inst_buf_valid <= 1'b0;
        end else if (~inst_buf_valid) begin
            inst_buf       <= inst_sram_rdata;
            inst_buf_valid <= 1'b1;
        end
    end

    assign ds_bus.pc   = pc_q;
    assign ds_bus.inst = inst_buf_valid ? inst_buf : inst_sram_rdata;

    assign fs_pc   = ds_bus.pc;
    assign fs_inst = ds_bus.inst;

endmodule
